// File: rtl/ber_pkg.sv
// Shared types and constants for the PRBS BER checker.
// BER_PRBS31_EN widens the history to 31 bits so PRBS31 can be checked.
package ber_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } ber_state_t;

    localparam int WORD_W = 64;
    localparam int NERR_W = 7;

    localparam int PRBS7_TAP_A  = 6;
    localparam int PRBS7_TAP_B  = 7;
    localparam int PRBS31_TAP_A = 28;
    localparam int PRBS31_TAP_B = 31;

`ifdef BER_PRBS31_EN
    localparam int HIST_W = PRBS31_TAP_B;
`else
    localparam int HIST_W = PRBS7_TAP_B;
`endif

endpackage

// File: rtl/ber_popcount64.sv
// Registered 64-to-7 population count, one cycle of latency.
module ber_popcount64
    import ber_pkg::*;
(
    input  logic              CLKS,
    input  logic              RSTXS,
    input  logic [WORD_W-1:0] i_din,
    output logic [NERR_W-1:0] o_cnt
);

    logic [NERR_W-1:0] w_sum;
    logic [NERR_W-1:0] r_cnt_p2;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < WORD_W; i++) begin
            w_sum = w_sum + NERR_W'(i_din[i]);
        end
    end

    // stage p1 -> p2
    always_ff @(posedge CLKS or negedge RSTXS) begin
        if (!RSTXS) begin
            r_cnt_p2 <= '0;
        end else begin
            r_cnt_p2 <= w_sum;
        end
    end

    assign o_cnt = r_cnt_p2;

endmodule

// File: rtl/ber_checker.sv
// Self-synchronizing PRBS BER checker with lock FSM and saturating counters.
// Optional feature macro: BER_PRBS31_EN (adds PRBS31 checking selected by POLY_SEL).
module ber_checker
    import ber_pkg::*;
#(
    parameter int LOCK_WORDS  = 4,
    parameter int UNLOCK_ERRS = 8,
    parameter int CNT_W       = 48
)
(
    input  logic              CLKS,
    input  logic              RSTXS,
    input  logic              CLKF,
    input  logic [WORD_W-1:0] DIN,
    input  logic              CLR,
    input  logic              POLY_SEL,
    output logic              LOCK,
    output logic              ERR_WORD,
    output logic [CNT_W-1:0]  BIT_CNT,
    output logic [CNT_W-1:0]  ERR_CNT
);

    localparam int E_W     = WORD_W + HIST_W;
    localparam int CLEAN_W = $clog2(LOCK_WORDS + 1);

    function automatic logic cnt_would_sat(input logic [CNT_W-1:0] cnt);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + (CNT_W + 1)'(WORD_W);
        return sum[CNT_W];
    endfunction

    logic r_clkf_s1, r_clkf_s2, r_clkf_s3;
    logic w_stb;

    logic [HIST_W-1:0] r_hist;
    logic [E_W-1:0]    w_e;
    logic [WORD_W-1:0] w_err;
    logic [WORD_W-1:0] r_err_p1;
    logic              r_vld_p1, r_nz_p1;

    logic [NERR_W-1:0] w_nerr_p2;
    logic              r_vld_p2, r_nz_p2;

    ber_state_t        r_state, w_state_nxt;
    logic [CLEAN_W-1:0] r_clean, w_clean_nxt;
    logic              w_poly_chg;
    logic              w_lock, w_acc, w_err_word_nxt;

    logic              r_err_word;
    logic [CNT_W-1:0]  r_bit_cnt, r_err_cnt;

    always_ff @(posedge CLKS or negedge RSTXS) begin
        if (!RSTXS) begin
            r_clkf_s1 <= 1'b0;
            r_clkf_s2 <= 1'b0;
            r_clkf_s3 <= 1'b0;
        end else begin
            r_clkf_s1 <= CLKF;
            r_clkf_s2 <= r_clkf_s1;
            r_clkf_s3 <= r_clkf_s2;
        end
    end

    // Falling edge of the synchronized word clock: DIN has been stable for a while.
    assign w_stb = !r_clkf_s2 && r_clkf_s3;

    assign w_e = {r_hist, DIN};

    always_comb begin
        w_err = '0;
        for (int i = 0; i < WORD_W; i++) begin
`ifdef BER_PRBS31_EN
            if (POLY_SEL) begin
                w_err[i] = w_e[i] ^ w_e[i + PRBS31_TAP_A] ^ w_e[i + PRBS31_TAP_B];
            end else begin
                w_err[i] = w_e[i] ^ w_e[i + PRBS7_TAP_A] ^ w_e[i + PRBS7_TAP_B];
            end
`else
            w_err[i] = w_e[i] ^ w_e[i + PRBS7_TAP_A] ^ w_e[i + PRBS7_TAP_B];
`endif
        end
    end

`ifdef BER_PRBS31_EN
    logic r_poly;

    always_ff @(posedge CLKS or negedge RSTXS) begin
        if (!RSTXS) begin
            r_poly <= 1'b0;
        end else begin
            r_poly <= POLY_SEL;
        end
    end

    assign w_poly_chg = POLY_SEL ^ r_poly;
`else
    logic w_unused_poly;

    assign w_unused_poly = POLY_SEL;
    assign w_poly_chg    = 1'b0;
`endif

    // stage p0 -> p1: error vector; history follows every word regardless of lock
    always_ff @(posedge CLKS or negedge RSTXS) begin
        if (!RSTXS) begin
            r_hist   <= '0;
            r_err_p1 <= '0;
            r_vld_p1 <= 1'b0;
            r_nz_p1  <= 1'b0;
        end else begin
            r_vld_p1 <= w_stb;
            if (w_stb) begin
                r_hist   <= DIN[HIST_W-1:0];
                r_err_p1 <= w_err;
                r_nz_p1  <= |DIN;
            end
        end
    end

    ber_popcount64 u_popcount (
        .CLKS  (CLKS),
        .RSTXS (RSTXS),
        .i_din (r_err_p1),
        .o_cnt (w_nerr_p2)
    );

    // stage p1 -> p2: qualifiers travel beside the popcount
    always_ff @(posedge CLKS or negedge RSTXS) begin
        if (!RSTXS) begin
            r_vld_p2 <= 1'b0;
            r_nz_p2  <= 1'b0;
        end else begin
            r_vld_p2 <= r_vld_p1;
            r_nz_p2  <= r_nz_p1;
        end
    end

    // stage p2 -> p3: lock FSM
    always_ff @(posedge CLKS or negedge RSTXS) begin
        if (!RSTXS) begin
            r_state <= HUNT;
            r_clean <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_clean <= w_clean_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clean_nxt = r_clean;
        if (CLR || w_poly_chg) begin
            w_state_nxt = HUNT;
            w_clean_nxt = '0;
        end else if (r_vld_p2) begin
            case (r_state)
                HUNT: begin
                    // all-zero words never count toward lock
                    if ((w_nerr_p2 == '0) && r_nz_p2) begin
                        if (r_clean == CLEAN_W'(LOCK_WORDS - 1)) begin
                            w_state_nxt = LOCKED;
                            w_clean_nxt = '0;
                        end else begin
                            w_clean_nxt = r_clean + CLEAN_W'(1);
                        end
                    end else begin
                        w_clean_nxt = '0;
                    end
                end
                LOCKED: begin
                    if (w_nerr_p2 >= NERR_W'(UNLOCK_ERRS)) begin
                        w_state_nxt = HUNT;
                    end
                end
                default: begin
                    w_state_nxt = HUNT;
                    w_clean_nxt = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_lock         = (r_state == LOCKED);
        w_acc          = !CLR && !w_poly_chg && r_vld_p2 && (r_state == LOCKED) &&
                         (w_nerr_p2 < NERR_W'(UNLOCK_ERRS));
        w_err_word_nxt = r_vld_p2 && (w_nerr_p2 != '0);
    end

    always_ff @(posedge CLKS or negedge RSTXS) begin
        if (!RSTXS) begin
            r_err_word <= 1'b0;
            r_bit_cnt  <= '0;
            r_err_cnt  <= '0;
        end else begin
            r_err_word <= w_err_word_nxt;
            if (CLR) begin
                r_bit_cnt <= '0;
                r_err_cnt <= '0;
            end else if (w_acc && !cnt_would_sat(r_bit_cnt)) begin
                // error count never exceeds bit count, so one guard freezes both
                r_bit_cnt <= r_bit_cnt + CNT_W'(WORD_W);
                r_err_cnt <= r_err_cnt + CNT_W'(w_nerr_p2);
            end
        end
    end

    assign LOCK     = w_lock;
    assign ERR_WORD = r_err_word;
    assign BIT_CNT  = r_bit_cnt;
    assign ERR_CNT  = r_err_cnt;

endmodule
